handshake_channel_arbiter: RTL and testbench
============================================

// Module: handshake_channel_arbiter
// PURPOSE
// - Shares one single-wire 4-phase handshake channel to a peer device among N_REQ local requesters.
// - Arbitration is round-robin.
// - Drives the local channel line (chan_req); samples the peer line (chan_ack).
// - A peer-initiated transfer (peer line high while idle) is accepted as a read and has priority over local writes.
// - Adds a write timeout so a silent peer cannot hang the local requesters.
// PARAMETERS
// - N_REQ    4    number of local requesters (>=2)
// - DATA_W   8    transfer data width
// - TIMEOUT  255  max cycles in WRITE waiting for peer ack before abort (>=1)
// PORTS
// - clk        in   1             clock, rising edge
// - reset      in   1             asynchronous, active-low
// - req        in   N_REQ         level request per requester; held until its done/err pulse
// - req_data   in   N_REQ*DATA_W  write data, slice i belongs to requester i
// - gnt        out  N_REQ         one-hot owner of the current write; 0 when none
// - done       out  N_REQ         1-cycle pulse: write to requester i completed
// - err        out  N_REQ         1-cycle pulse: write to requester i aborted on timeout
// - chan_req   out  1             local handshake line to peer
// - chan_wdata out  DATA_W        write data to peer; stable while chan_req=1 and through DONE
// - chan_ack   in   1             peer handshake line, synchronous to clk
// - chan_rdata in   DATA_W        peer read data, valid when peer raises chan_ack from idle
// - rd_data    out  DATA_W        last captured peer data
// - rd_valid   out  1             1-cycle pulse: peer read completed, rd_data valid
// BEHAVIOUR
// - Reset: state=IDLE, gnt=0, done=0, err=0, chan_req=0, chan_wdata=0, rd_data=0, rd_valid=0, rr pointer=0, timer=0.
// - States: IDLE, WRITE, DONE, READ, ABORT. chan_req is decoded from state: 1 in WRITE and READ; 0 otherwise.
// - IDLE, chan_ack=1: go to READ. Capture chan_rdata into rd_data on that edge. Local reqs wait (peer priority).
// - IDLE, chan_ack=0, req!=0: pick winner w = first set req at/after the rr pointer, wrapping modulo N_REQ.
//   On the same edge: gnt<=onehot(w), chan_wdata<=req_data[w], timer<=0, pointer<=w+1 (wrap), go to WRITE.
// - IDLE, chan_ack=0, req=0: stay in IDLE.
// - Latency: req sampled high at edge k in IDLE gives chan_req=1 during cycle k+1.
// - WRITE, chan_ack=1: go to DONE.
// - WRITE, chan_ack=0: timer++. When timer==TIMEOUT-1, go to ABORT. So at most TIMEOUT cycles are spent in WRITE.
// - DONE (chan_req=0), chan_ack=0: go to IDLE, gnt<=0.
//   - done = gnt & {N_REQ{state==DONE && !chan_ack}} (combinational, same cycle).
//   - DONE has no timeout.
// - ABORT (chan_req=0), chan_ack=0: go to IDLE, gnt<=0, err = gnt, same rule as done.
//   - Otherwise wait in ABORT for chan_ack to fall.
// - READ (chan_req=1 acts as ack), chan_ack=0: go to IDLE. rd_valid=1 in that cycle (combinational).
//   - Otherwise stay in READ.
// - Requester contract: if no further transfer is wanted, drop req on the edge that samples done/err.
//   - A req still high in the next IDLE cycle is a new request.
// - req dropped mid-transfer: ignored. The transfer completes normally and still pulses done/err.
// - req and req_data changes after grant do not affect chan_wdata.
// - Peer raises chan_ack on the same edge that local arbitration would grant: READ wins, no gnt issued.
// - Pointer advances only on a grant. Reads do not move it.
// - Reset asserted mid-transfer: immediate return to reset values.
//   - chan_req drops asynchronously. No done/err pulse is issued.
// TESTING
// - Single write: N_REQ=4, req=0010, data1=8'hA5, peer acks 3 cycles after chan_req rises and drops 2 cycles later.
//   - Expect gnt=0010, chan_wdata=A5 through DONE, done=0010 for 1 cycle, chan_req high for exactly 4 cycles.
// - Round robin: req=1111 held; each write acked.
//   - Expect grant order 0,1,2,3,0 with gnt one-hot and never overlapping.
// - Peer priority: chan_ack rises with chan_rdata=8'h3C on the same edge req=0001 arrives.
//   - Expect READ, chan_req=1 until chan_ack falls, rd_valid pulse with rd_data=3C.
//   - Then the write to requester 0 is granted.
// - Timeout: TIMEOUT=8, req=0100, peer never acks.
//   - Expect chan_req high exactly 8 cycles, then ABORT, err=0100 one cycle, done never asserted.
// - Reset mid-WRITE: assert reset while chan_req=1.
//   - Expect chan_req=0 and gnt=0 immediately, no done/err pulse, next grant starts from requester 0.
// - Req drop: requester 2 drops req during WRITE.
//   - Expect the transfer to finish and done=0100 to pulse.

Source files
------------

// File: rtl/handshake_channel_arbiter.sv
// Round-robin arbiter sharing one 4-phase handshake channel among N_REQ local writers,
// with peer-initiated reads taking priority and a write timeout against a silent peer.
module handshake_channel_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    output logic                      chan_req,
    output logic [DATA_W-1:0]         chan_wdata,
    input  logic                      chan_ack,
    input  logic [DATA_W-1:0]         chan_rdata,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        DONE,
        READ,
        ABORT
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [TW-1:0]     timer;

    logic              found;
    logic [PW-1:0]     win;
    logic [N_REQ-1:0]  win_oh;
    logic [DATA_W-1:0] win_data;
    logic [PW-1:0]     ptr_next;

    // Two passes: first requesters at/after the pointer, then wrap to those below it.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_oh   = '0;
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                found    = 1'b1;
                win      = PW'(i);
                win_oh   = '0;
                win_oh[i] = 1'b1;
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                win      = PW'(i);
                win_oh   = '0;
                win_oh[i] = 1'b1;
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        ptr_next = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gnt        <= '0;
            chan_wdata <= '0;
            rd_data    <= '0;
            ptr        <= '0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (chan_ack) begin
                        state   <= READ;
                        rd_data <= chan_rdata;
                    end else if (found) begin
                        state      <= WRITE;
                        gnt        <= win_oh;
                        chan_wdata <= win_data;
                        timer      <= '0;
                        ptr        <= ptr_next;
                    end
                end
                WRITE: begin
                    if (chan_ack) begin
                        state <= DONE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state <= ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE, ABORT: begin
                    if (!chan_ack) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                READ: begin
                    if (!chan_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from state so an asynchronous reset drops the line at once.
    assign chan_req = (state == WRITE) || (state == READ);
    assign done     = gnt & {N_REQ{(state == DONE) && !chan_ack}};
    assign err      = gnt & {N_REQ{(state == ABORT) && !chan_ack}};
    assign rd_valid = (state == READ) && !chan_ack;

endmodule

// File: tb/tb_handshake_channel_arbiter.sv
// Self-checking bench: directed scenarios plus randomized reads/writes checked against
// a transaction-level model of arbitration order, handshake timing and timeout.
module tb_handshake_channel_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TP = 8;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic [NR-1:0]   err;
    logic            chan_req;
    logic [DW-1:0]   chan_wdata;
    logic            chan_ack;
    logic [DW-1:0]   chan_rdata;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;
    logic [DW-1:0] last_rd = '0;

    handshake_channel_arbiter #(.N_REQ(NR), .DATA_W(DW), .TIMEOUT(TP)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .chan_req(chan_req),
        .chan_wdata(chan_wdata), .chan_ack(chan_ack), .chan_rdata(chan_rdata),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // One write: peer raises ack d cycles after chan_req rises, holds it h cycles; silent = never acks.
    task automatic write_txn(input logic [NR-1:0] reqv, input int d, input int h,
                             input bit silent, input bit drop_mid, input int fixed);
        logic [NR*DW-1:0] data0;
        logic [NR-1:0]    oh;
        int w, wlen, endc;
        bit acked;
        @(posedge clk); #1;
        data0 = {$urandom};
        w = pick(reqv, ptr_m);
        if (fixed >= 0) data0[w*DW +: DW] = DW'(fixed);
        req = reqv; req_data = data0; chan_ack = 1'b0; chan_rdata = DW'($urandom);
        oh = '0; oh[w] = 1'b1;
        acked = !silent && (d + 1 <= TP);
        wlen = acked ? d + 1 : TP;
        endc = acked ? d + h + 1 : TP + 1;
        @(negedge clk);
        chk("wr_idle_chan_req", 32'(chan_req), 32'(0));
        chk("wr_idle_gnt", 32'(gnt), 32'(0));
        chk("wr_idle_rd_valid", 32'(rd_valid), 32'(0));
        ptr_m = (w + 1) % NR;
        for (int c = 1; c <= endc; c++) begin
            @(posedge clk); #1;
            chan_ack = !silent && (c >= d + 1) && (c <= d + h);
            req_data = {$urandom};
            chan_rdata = DW'($urandom);
            if (drop_mid && c == 2) req[w] = 1'b0;
            @(negedge clk);
            chk("wr_chan_req", 32'(chan_req), 32'(c <= wlen));
            chk("wr_gnt", 32'(gnt), 32'(oh));
            chk("wr_wdata", 32'(chan_wdata), 32'(data0[w*DW +: DW]));
            chk("wr_done", 32'(done), 32'((acked && c == endc) ? oh : 4'b0));
            chk("wr_err", 32'(err), 32'((!acked && c == endc) ? oh : 4'b0));
            chk("wr_rd_valid", 32'(rd_valid), 32'(0));
            chk("wr_rd_data", 32'(rd_data), 32'(last_rd));
        end
    endtask

    // One peer read: ack rises in the idle cycle with rd on the line, falls after h cycles of READ.
    task automatic read_txn(input logic [NR-1:0] reqv, input logic [DW-1:0] rd, input int h);
        @(posedge clk); #1;
        req = reqv; req_data = {$urandom}; chan_ack = 1'b1; chan_rdata = rd;
        @(negedge clk);
        chk("rd_idle_chan_req", 32'(chan_req), 32'(0));
        chk("rd_idle_rd_data", 32'(rd_data), 32'(last_rd));
        for (int c = 1; c <= h; c++) begin
            @(posedge clk); #1;
            chan_ack = (c < h);
            chan_rdata = DW'($urandom);
            @(negedge clk);
            chk("rd_chan_req", 32'(chan_req), 32'(1));
            chk("rd_gnt", 32'(gnt), 32'(0));
            chk("rd_valid", 32'(rd_valid), 32'(c == h));
            chk("rd_data", 32'(rd_data), 32'(rd));
            chk("rd_done_err", 32'({done, err}), 32'(0));
        end
        last_rd = rd;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        req = '0; chan_ack = 1'b0;
        @(negedge clk);
        chk("idle_chan_req", 32'(chan_req), 32'(0));
        chk("idle_gnt", 32'(gnt), 32'(0));
        chk("idle_done_err", 32'({done, err}), 32'(0));
    endtask

    initial begin
        reset = 1'b0; req = '0; req_data = '0; chan_ack = 1'b0; chan_rdata = '0;
        #12;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_chan_req", 32'(chan_req), 32'(0));
        chk("rst_wdata", 32'(chan_wdata), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_pulses", 32'({done, err, rd_valid}), 32'(0));
        @(negedge clk); reset = 1'b1;

        // single write to requester 1 with data A5
        write_txn(4'b0010, 3, 2, 1'b0, 1'b0, 8'hA5);
        // round robin from pointer 2: 2,3,0,1,2
        for (int k = 0; k < 5; k++) write_txn(4'b1111, 1, 1, 1'b0, 1'b0, -1);
        // peer priority over a fresh request, then that request is served
        read_txn(4'b0001, 8'h3C, 3);
        write_txn(4'b0001, 0, 1, 1'b0, 1'b0, -1);
        // timeout with silent peer
        write_txn(4'b0100, 0, 0, 1'b1, 1'b0, -1);
        // ack in the last allowed WRITE cycle still completes
        write_txn(4'b0100, TP - 1, 2, 1'b0, 1'b0, -1);
        // requester 2 drops req mid-transfer
        write_txn(4'b0100, 2, 1, 1'b0, 1'b1, -1);
        idle_cycle();

        // randomized mix
        for (int t = 0; t < 60; t++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 3)
                read_txn(NR'($urandom_range(0, 15)), DW'($urandom), $urandom_range(1, 4));
            else if (kind == 3)
                write_txn(NR'($urandom_range(1, 15)), 0, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
            else if (kind == 4)
                idle_cycle();
            else
                write_txn(NR'($urandom_range(1, 15)), $urandom_range(0, TP - 1),
                          $urandom_range(1, 3), 1'b0, 1'($urandom_range(0, 1)), -1);
        end

        // reset mid-WRITE: make pointer nonzero and rd_data nonzero first
        read_txn(4'b0000, 8'h5A, 1);
        @(posedge clk); #1;
        req = 4'b0010; chan_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_chan_req", 32'(chan_req), 32'(1));
        chk("pre_rst_gnt", 32'(gnt), 32'(4'b0010));
        #1 reset = 1'b0;
        #1;
        chk("async_rst_chan_req", 32'(chan_req), 32'(0));
        chk("async_rst_gnt", 32'(gnt), 32'(0));
        chk("async_rst_pulses", 32'({done, err, rd_valid}), 32'(0));
        chk("async_rst_rd_data", 32'(rd_data), 32'(0));
        req = '0;
        @(posedge clk); #1;
        chk("held_rst_pulses", 32'({done, err, chan_req}), 32'(0));
        @(negedge clk); reset = 1'b1;
        ptr_m = 0; last_rd = '0;
        write_txn(4'b1111, 1, 1, 1'b0, 1'b0, -1);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
